fft_input_framer: RTL

//  Upstream feeder for the 32-point FFT datapath. Accepts a serial stream of complex samples
//  (valid/ready) and assembles 32-sample frames in a ping-pong pair of register banks.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_frame_bank.sv | 46 ++++
 rtl/fft_input_framer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, sample type and slot-ordering helper for the FFT input framer
// Contents:
//   NPOINT   frame length in samples (32)
//   LOG2N    slot index width (5)
//   sample_t one {re, im} sample at the default 16-bit component width
//   bitrev5  5-bit bit reversal used for decimation-in-time slot ordering
package fft_pkg;

    localparam int NPOINT       = 32;
    localparam int LOG2N        = 5;
    localparam int DEFAULT_BITS = 16;

    typedef logic [2*DEFAULT_BITS-1:0] sample_t;

    function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] n);
        return {n[0], n[1], n[2], n[3], n[4]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one 32-slot sample register bank with a full flag
// Ports:
//   clk, rst_n          clock and asynchronous active-low clear of contents and flag
//   we, slot, data      write port: data lands in slot when we is high
//   set_full, clr_full  full flag control; set takes priority
//   full                bank holds a complete frame
//   rd_bus              flat read bus, slot k at [k*sample_w +: sample_w]
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int sample_w = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [LOG2N-1:0]           slot,
    input  logic [sample_w-1:0]        data,
    input  logic                       set_full,
    input  logic                       clr_full,
    output logic                       full,
    output logic [NPOINT*sample_w-1:0] rd_bus
);

    logic [NPOINT-1:0][sample_w-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem[slot] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (set_full) begin
            full <= 1'b1;
        end else if (clr_full) begin
            full <= 1'b0;
        end
    end

    assign rd_bus = mem;

endmodule

// File: rtl/fft_input_framer.sv
// rtl/fft_input_framer.sv - assembles serial complex samples into ping-pong 32-slot frames
// Build option: define BIT_REVERSE_EN to store sample n in slot bitrev5(n) (decimation-in-time
// input order); leave it undefined to store sample n in slot n.
// Ports:
//   clk_100, reset       clock and asynchronous active-low reset
//   s_data/s_valid/      sample input {re, im}; s_first marks sample 0 of a new frame
//   s_first/s_ready
//   frame_out            32 slots of 2*bits, slot k at [k*2*bits +: 2*bits]; zero when no frame
//   frame_valid          frame_out holds a complete frame
//   frame_ack            consumer releases the presented bank
//   frame_err            one-cycle pulse when a partial frame is discarded
//   frame_cnt            completed frame count, wraps
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int bits    = 16,
    parameter int fix_bit = 7
) (
    input  logic                         clk_100,
    input  logic                         reset,
    input  logic [2*bits-1:0]            s_data,
    input  logic                         s_valid,
    input  logic                         s_first,
    output logic                         s_ready,
    output logic [NPOINT*2*bits-1:0]     frame_out,
    output logic                         frame_valid,
    input  logic                         frame_ack,
    output logic                         frame_err,
    output logic [7:0]                   frame_cnt
);

    localparam int SW = 2*bits;

    // fix_bit describes the downstream number format only; reject impossible settings early.
    if ((fix_bit < 0) || (fix_bit >= bits)) begin : g_bad_fix_bit
        $error("fix_bit must lie in [0, bits)");
    end

    logic [LOG2N-1:0]        wr_cnt;
    logic                    wr_bank;
    logic                    rd_bank;
    logic                    run_q;
    logic [1:0]              full;
    logic [NPOINT*SW-1:0]    rd_bus [2];
    logic                    accept;
    logic                    restart;
    logic                    last;
    logic                    release_rd;
    logic [LOG2N-1:0]        wr_n;
    logic [LOG2N-1:0]        wr_slot;
    logic [1:0]              we;
    logic [1:0]              set_full;
    logic [1:0]              clr_full;

    // run_q keeps s_ready low while reset is asserted and for the first cycle after release.
    assign s_ready     = run_q && !full[wr_bank];
    assign frame_valid = full[rd_bank];
    assign accept      = s_valid && s_ready;
    assign restart     = s_first && (wr_cnt != '0);
    assign wr_n        = restart ? '0 : wr_cnt;
    assign last        = !restart && (wr_cnt == LOG2N'(NPOINT-1));
    assign release_rd  = frame_ack && frame_valid;

`ifdef BIT_REVERSE_EN
    assign wr_slot = bitrev5(wr_n);
`else
    assign wr_slot = wr_n;
`endif

    // Write and release can target different banks on the same edge; the write side never
    // targets a full bank, so set and clear never collide on one bank.
    always_comb begin
        we       = '0;
        set_full = '0;
        clr_full = '0;
        we[wr_bank]       = accept;
        set_full[wr_bank] = accept && last;
        clr_full[rd_bank] = release_rd;
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_frame_bank #(
            .sample_w (SW)
        ) u_bank (
            .clk      (clk_100),
            .rst_n    (reset),
            .we       (we[g]),
            .slot     (wr_slot),
            .data     (s_data),
            .set_full (set_full[g]),
            .clr_full (clr_full[g]),
            .full     (full[g]),
            .rd_bus   (rd_bus[g])
        );
    end

    assign frame_out = frame_valid ? rd_bus[rd_bank] : '0;

    always_ff @(posedge clk_100 or negedge reset) begin
        if (!reset) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            run_q     <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            run_q     <= 1'b1;
            frame_err <= 1'b0;
            if (accept) begin
                if (restart) begin
                    // The restart sample is stored as sample 0 of the same bank.
                    wr_cnt    <= LOG2N'(1);
                    frame_err <= 1'b1;
                end else if (last) begin
                    wr_cnt    <= '0;
                    wr_bank   <= ~wr_bank;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    wr_cnt <= wr_cnt + LOG2N'(1);
                end
            end
            if (release_rd) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

endmodule
